// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: flow opcodes, FSM states, default PC width.
// Build option: STACK_ERR_HALT_EN makes a return-stack error on CALL/RET enter FAULT.
package pc_seq_pkg;

    localparam int PC_WIDTH_DEFAULT = 13;

    typedef enum logic [2:0] {
        OP_SEQ    = 3'b000,
        OP_JUMP   = 3'b001,
        OP_BRANCH = 3'b010,
        OP_CALL   = 3'b011,
        OP_RET    = 3'b100,
        OP_HALT   = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } seq_state_t;

    // True for the two opcodes that talk to the return stack.
    function automatic logic is_stack_op(input logic [2:0] op);
        return (op == OP_CALL) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the sequencer (master) and its decoder/return-stack environment (slave).
// Build option: STACK_ERR_HALT_EN (affects only how Stack_Err is interpreted).
interface pc_sequencer_if #(
    parameter int PC_WIDTH = pc_seq_pkg::PC_WIDTH_DEFAULT
);
    // Stack handshake: Stack_Enable is a one-cycle request with no ready; the
    // stack completes it on the falling edge, and Ret_Add/Stack_Err are then
    // stable for the sequencer to sample on the following rising edge.
    logic [2:0]          Op;
    logic                Cond;
    logic [PC_WIDTH-1:0] Target;
    logic                Stall;
    logic                Resume;
    logic [PC_WIDTH-1:0] Ret_Add;
    logic                Stack_Err;
    logic [PC_WIDTH-1:0] PC;
    logic [PC_WIDTH-1:0] NPPC;
    logic                Stack_Enable;
    logic                Stack_Write;
    logic                Halted;
    logic                Fault;

    modport master (
        input  Op, Cond, Target, Stall, Resume, Ret_Add, Stack_Err,
        output PC, NPPC, Stack_Enable, Stack_Write, Halted, Fault
    );

    modport slave (
        output Op, Cond, Target, Stall, Resume, Ret_Add, Stack_Err,
        input  PC, NPPC, Stack_Enable, Stack_Write, Halted, Fault
    );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection used while the sequencer is in RUN.
// Build option: STACK_ERR_HALT_EN selects how a stack error on CALL/RET steers the PC.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEFAULT
) (
    input  logic [2:0]          op,
    input  logic                cond,
    input  logic [PC_WIDTH-1:0] target,
    input  logic [PC_WIDTH-1:0] ret_add,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                stack_err,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic [PC_WIDTH-1:0] nppc
);

    always_comb begin
        nppc    = pc + PC_WIDTH'(1);
        next_pc = nppc;
        case (op)
            OP_JUMP:   next_pc = target;
            OP_BRANCH: next_pc = cond ? target : nppc;
`ifdef STACK_ERR_HALT_EN
            // A failed stack access freezes the PC; the FSM moves to FAULT.
            OP_CALL:   next_pc = stack_err ? pc : target;
            OP_RET:    next_pc = stack_err ? pc : ret_add;
`else
            // Errors are ignored: a bad pop falls through instead of using garbage.
            OP_CALL:   next_pc = target;
            OP_RET:    next_pc = stack_err ? nppc : ret_add;
`endif
            OP_HALT:   next_pc = pc;
            default:   next_pc = nppc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/HALT/FAULT FSM and PC register, driving a falling-edge return stack.
// Build option: STACK_ERR_HALT_EN enables the FAULT state on return-stack errors.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  Slow_Clock,
    input  logic                  Reset,
    pc_sequencer_if.master        bus,
    output seq_state_t            dbg_state
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] nppc;
    seq_state_t          state_q;
    logic                halted_q;
    logic                fault_q;
    logic                stack_req;

    pc_next_mux #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_mux (
        .op        (bus.Op),
        .cond      (bus.Cond),
        .target    (bus.Target),
        .ret_add   (bus.Ret_Add),
        .pc        (pc_q),
        .stack_err (bus.Stack_Err),
        .next_pc   (next_pc),
        .nppc      (nppc)
    );

    // Reset is in the term so an asserted reset kills a request in flight.
    assign stack_req = (state_q == ST_RUN) && !bus.Stall && !Reset && is_stack_op(bus.Op);

    assign bus.Stack_Enable = stack_req;
    assign bus.Stack_Write  = stack_req && (bus.Op == OP_CALL);
    assign bus.PC           = pc_q;
    assign bus.NPPC         = nppc;
    assign bus.Halted       = halted_q;
    assign bus.Fault        = fault_q;
    assign dbg_state        = state_q;

    always_ff @(posedge Slow_Clock or posedge Reset) begin
        if (Reset) begin
            pc_q     <= RESET_VECTOR;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (!bus.Stall) begin
            case (state_q)
                ST_RUN: begin
                    pc_q <= next_pc;
                    if (bus.Op == OP_HALT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
`ifdef STACK_ERR_HALT_EN
                    else if (is_stack_op(bus.Op) && bus.Stack_Err) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end
`endif
                end
                ST_HALT: begin
                    if (bus.Resume) begin
                        pc_q     <= nppc;
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                // FAULT is sticky: only Reset leaves it.
                ST_FAULT: begin
                    pc_q <= pc_q;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                    fault_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against a behavioural model with a return stack.
// Build option: STACK_ERR_HALT_EN switches the model's stack-error behaviour to match.
`timescale 1ns/1ps
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int W           = 13;
    localparam int STACK_DEPTH = 6;

    logic       Slow_Clock = 1'b0;
    logic       Reset      = 1'b1;
    seq_state_t dbg_state;

    pc_sequencer_if #(.PC_WIDTH(W)) bus ();

    pc_sequencer #(
        .PC_WIDTH     (W),
        .RESET_VECTOR (13'h0000)
    ) dut (
        .Slow_Clock (Slow_Clock),
        .Reset      (Reset),
        .bus        (bus),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    always #5 Slow_Clock = ~Slow_Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state: model PC/flags plus the return-address stack (expected pops)
    int             n_checks = 0;
    int             n_errors = 0;
    logic [W-1:0]   m_pc;
    bit             m_halted;
    bit             m_fault;
    logic [W-1:0]   exp_q[$];
    logic           seen_en;
    logic           seen_we;
    logic [W-1:0]   seen_nppc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at #1 after a rising edge; asserts reset with a CALL pending.
    task automatic do_reset();
        bus.Op        = OP_CALL;
        bus.Cond      = 1'b0;
        bus.Target    = W'($urandom);
        bus.Stall     = 1'b0;
        bus.Resume    = 1'b0;
        bus.Stack_Err = 1'b0;
        bus.Ret_Add   = '0;
        #2 Reset = 1'b1;
        #1;
        check("rst_pc", bus.PC, 0);
        check("rst_stack_en", bus.Stack_Enable, 0);
        check("rst_stack_we", bus.Stack_Write, 0);
        check("rst_halted", bus.Halted, 0);
        check("rst_fault", bus.Fault, 0);
        @(posedge Slow_Clock);
        #1 Reset = 1'b0;
        m_pc     = '0;
        m_halted = 0;
        m_fault  = 0;
        exp_q.delete();
    endtask

    // Driver: one full cycle, stack served on the falling edge, outputs checked after the rising edge.
    task automatic step(input logic [2:0] op, input logic cond, input logic [W-1:0] tgt,
                        input logic stall, input logic resume, input logic force_err);
        logic         exp_en;
        logic         exp_we;
        logic         err;
        logic [W-1:0] ret;
        logic [W-1:0] nppc_m;
        bus.Op        = op;
        bus.Cond      = cond;
        bus.Target    = tgt;
        bus.Stall     = stall;
        bus.Resume    = resume;
        bus.Stack_Err = 1'b0;
        bus.Ret_Add   = W'($urandom);
        nppc_m = m_pc + 1'b1;
        exp_en = !m_halted && !m_fault && !stall && (op == OP_CALL || op == OP_RET);
        exp_we = exp_en && (op == OP_CALL);
        @(negedge Slow_Clock);
        seen_en   = bus.Stack_Enable;
        seen_we   = bus.Stack_Write;
        seen_nppc = bus.NPPC;
        check("stack_en", bus.Stack_Enable, exp_en);
        if (exp_en) check("stack_we", bus.Stack_Write, exp_we);
        check("nppc", bus.NPPC, nppc_m);
        err = force_err;
        ret = bus.Ret_Add;
        if (exp_en) begin
            if (op == OP_CALL) begin
                if (exp_q.size() >= STACK_DEPTH) err = 1'b1;
                if (!err) exp_q.push_back(nppc_m);
            end else begin
                if (exp_q.size() == 0) err = 1'b1;
                if (!err) ret = exp_q.pop_back();
            end
        end
        // Outside a stack op the error line is noise the sequencer must ignore.
        bus.Stack_Err = err;
        bus.Ret_Add   = ret;
        if (!m_fault && !stall) begin
            if (m_halted) begin
                if (resume) begin
                    m_pc     = nppc_m;
                    m_halted = 0;
                end
            end else begin
                case (op)
                    OP_JUMP:   m_pc = tgt;
                    OP_BRANCH: m_pc = cond ? tgt : nppc_m;
                    OP_CALL: begin
`ifdef STACK_ERR_HALT_EN
                        if (err) m_fault = 1; else m_pc = tgt;
`else
                        m_pc = tgt;
`endif
                    end
                    OP_RET: begin
`ifdef STACK_ERR_HALT_EN
                        if (err) m_fault = 1; else m_pc = ret;
`else
                        m_pc = err ? nppc_m : ret;
`endif
                    end
                    OP_HALT:   m_halted = 1;
                    default:   m_pc = nppc_m;
                endcase
            end
        end
        @(posedge Slow_Clock);
        #1;
        check("pc", bus.PC, m_pc);
        check("halted", bus.Halted, m_halted);
        check("fault", bus.Fault, m_fault);
    endtask

    initial begin
        bus.Op = OP_SEQ; bus.Cond = 0; bus.Target = '0; bus.Stall = 0;
        bus.Resume = 0; bus.Stack_Err = 0; bus.Ret_Add = '0;
        @(posedge Slow_Clock);
        #1;
        do_reset();
        check("reset_state", dbg_state, ST_RUN);

        // Sequential fetch from reset
        for (int i = 1; i <= 3; i++) begin
            step(OP_SEQ, 0, W'($urandom), 0, 0, 0);
            check("seq_pc", bus.PC, i);
            check("seq_no_stack", seen_en, 0);
        end

        // CALL then RET
        step(OP_JUMP, 0, 13'h0010, 0, 0, 0);
        step(OP_CALL, 0, 13'h0100, 0, 0, 0);
        check("call_pc", bus.PC, 13'h0100);
        check("call_we", seen_we, 1);
        check("call_push", seen_nppc, 13'h0011);
        step(OP_RET, 0, 13'h0aaa, 0, 0, 0);
        check("ret_pc", bus.PC, 13'h0011);
        check("ret_en", seen_en, 1);
        check("ret_we", seen_we, 0);

        // Wrap at the top of the address space
        step(OP_JUMP, 0, 13'h1fff, 0, 0, 0);
        step(OP_SEQ, 0, 13'h0123, 0, 0, 0);
        check("wrap_pc", bus.PC, 0);
        step(OP_JUMP, 0, 13'h1fff, 0, 0, 0);
        step(OP_CALL, 0, 13'h0020, 0, 0, 0);
        check("wrap_push", seen_nppc, 0);
        step(OP_RET, 0, 13'h0555, 0, 0, 0);
        check("wrap_ret_pc", bus.PC, 0);

        // Branch both ways, then stall with a CALL presented
        step(OP_JUMP, 0, 13'h0005, 0, 0, 0);
        step(OP_BRANCH, 0, 13'h0040, 0, 0, 0);
        check("br_nt_pc", bus.PC, 6);
        step(OP_BRANCH, 1, 13'h0040, 0, 0, 0);
        check("br_t_pc", bus.PC, 13'h0040);
        for (int i = 0; i < 2; i++) begin
            step(OP_CALL, 1, 13'h0333, 1, 1, 0);
            check("stall_pc", bus.PC, 13'h0040);
            check("stall_no_stack", seen_en, 0);
        end

        // HALT, ignore ops, then resume
        step(OP_JUMP, 0, 13'h0007, 0, 0, 0);
        step(OP_HALT, 0, 13'h0999, 0, 0, 0);
        check("halt_flag", bus.Halted, 1);
        for (int i = 0; i < 4; i++) begin
            step(3'($urandom_range(0, 7)), 1, W'($urandom), 0, 0, 0);
            check("halt_hold_pc", bus.PC, 7);
            check("halt_no_stack", seen_en, 0);
        end
        step(OP_JUMP, 0, 13'h0444, 0, 1, 0);
        check("resume_pc", bus.PC, 8);
        check("resume_state", dbg_state, ST_RUN);

        // RET with a stack error
        step(OP_JUMP, 0, 13'h0009, 0, 0, 0);
        step(OP_RET, 0, 13'h0000, 0, 0, 1);
`ifdef STACK_ERR_HALT_EN
        check("err_fault", bus.Fault, 1);
        check("err_pc", bus.PC, 9);
        for (int i = 0; i < 3; i++) begin
            step(OP_CALL, 0, 13'h0077, 0, 1, 0);
            check("fault_hold_pc", bus.PC, 9);
            check("fault_no_stack", seen_en, 0);
        end
        do_reset();
        check("fault_reset_pc", bus.PC, 0);
        check("fault_reset_state", dbg_state, ST_RUN);
`else
        check("err_pc", bus.PC, 10);
        check("err_no_fault", bus.Fault, 0);
`endif

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 80) == 0) begin
                do_reset();
            end else begin
                step(3'($urandom_range(0, 7)), 1'($urandom), W'($urandom),
                     $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 15) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 13, the program-counter width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 13'h0000, the PC value loaded on reset.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, using the codebase's port names Slow_Clock and Reset.
REQ-004 Slow_Clock  input  1  clock; PC state updates on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Op  input  3  decoded flow op: 000 SEQ, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101 HALT; 110/111 treated as SEQ.
REQ-007 Cond  input  1  branch condition; used only when Op=BRANCH.
REQ-008 Target  input  PC_WIDTH  jump, branch or call destination.
REQ-009 Stall  input  1  when high, hold all state and suppress stack requests.
REQ-010 Resume  input  1  leave HALT.
REQ-011 Ret_Add  input  PC_WIDTH  popped return address from the return stack, valid before the next rising edge.
REQ-012 Stack_Err  input  1  overflow/underflow flag from the return stack.
REQ-013 PC  output  PC_WIDTH  current program counter.
REQ-014 NPPC  output  PC_WIDTH  PC+1 (mod 2^PC_WIDTH), combinational; this is the push data.
REQ-015 Stack_Enable  output  1  stack request, combinational.
REQ-016 Stack_Write  output  1  1 = push, 0 = pop; meaningful only with Stack_Enable.
REQ-017 Halted  output  1  high in the HALT state.
REQ-018 Fault  output  1  high in the FAULT state.

Function
REQ-019 SHALL implement a three-state FSM: RUN, HALT, FAULT.
REQ-020 In RUN with Stall=0, next PC SHALL be:
- SEQ: NPPC
- JUMP: Target
- BRANCH: Target if Cond=1, else NPPC
- CALL: Target
- RET: Ret_Add
- HALT: PC held, state goes to HALT
REQ-021 Stack_Enable SHALL be 1 only in RUN, with Stall=0 and Reset=0, and Op=CALL (with Stack_Write=1) or Op=RET (with Stack_Write=0); otherwise both outputs SHALL be 0.
REQ-022 The stack acts on the falling edge mid-cycle, so the sequencer SHALL sample Ret_Add and Stack_Err at the following rising edge; CALL/RET have one-cycle latency with no wait state.
REQ-023 Stall=1 SHALL hold PC and state for every cycle it is asserted, in any state.
REQ-024 In HALT, PC SHALL be held; Resume=1 (with Stall=0) SHALL set PC=NPPC and state=RUN; Op SHALL be ignored.
REQ-025 PC arithmetic SHALL wrap: at PC=13'h1FFF, NPPC=13'h0000; a CALL at 13'h1FFF SHALL push 13'h0000.
REQ-026 Stack_Err sampled high on a CALL/RET edge SHALL be handled as set by REQ-030/031.
REQ-027 In FAULT, PC SHALL be held, stack requests suppressed and Resume ignored; only Reset SHALL exit FAULT.

Reset
REQ-028 Reset=1 SHALL asynchronously force PC=RESET_VECTOR, state=RUN, Halted=0, Fault=0.
REQ-029 While Reset=1, Stack_Enable=0 and Stack_Write=0; a reset asserted mid-CALL/RET SHALL abort the request with no PC update.

Configuration
REQ-030 With STACK_ERR_HALT_EN defined, Stack_Err on a CALL/RET edge SHALL leave PC unchanged and enter FAULT (Fault=1).
REQ-031 Without STACK_ERR_HALT_EN, Stack_Err SHALL be ignored: CALL loads Target, RET loads NPPC (Ret_Add discarded), the FSM stays in RUN, and Fault is tied 0.

Structure
REQ-032 The shared package pc_seq_pkg SHALL hold the opcode enum, the state enum, and the PC_WIDTH default.
REQ-033 Next-PC selection SHALL be a combinational sub-module, pc_next_mux; the FSM and PC register stay in pc_sequencer.

Verification
REQ-034 Bench SHALL cover the following directed scenarios:
- Reset, then SEQ for 3 cycles -> PC=0,1,2,3; Stack_Enable=0 throughout.
- PC=13'h0010, CALL Target=13'h0100, then RET with Ret_Add=13'h0011 -> push with NPPC=13'h0011, PC=13'h0100, then PC=13'h0011; Stack_Write=1 then 0.
- PC=13'h1FFF, SEQ -> PC=13'h0000; CALL at 13'h1FFF -> NPPC pushed=13'h0000.
- BRANCH Target=13'h0040: Cond=0 at PC=5 -> PC=6; Cond=1 -> PC=13'h0040; Stall=1 for 2 cycles -> PC held, no stack request.
- HALT at PC=7 -> Halted=1, PC=7 held for 4 cycles; Resume=1 -> PC=8, RUN.
- RET with Stack_Err=1 at PC=9 -> with STACK_ERR_HALT_EN: Fault=1, PC=9 held until Reset, and Reset mid-FAULT -> PC=0; without it: PC=10, Fault=0.
